// File: rtl/sc_intr_ctrl.sv
// sc_intr_ctrl: priority interrupt controller in front of the single-cycle
// interrupt CPU.
// - Synchronises NSRC device request lines and applies a software mask.
// - Grants the highest-priority candidate (bit 0 highest) over the intr/inta
//   handshake.
// - Holds the granted source in service until eoi.
// Optional feature macro: SC_INTR_EDGE_EN.
//   Defined:   edge-triggered pending bits, cleared on inta for the granted source.
//   Undefined: pending mirrors the synchronised request levels.
module sc_intr_ctrl #(
  parameter int unsigned     NSRC       = 8,
  parameter int unsigned     ID_W       = 3,
  parameter logic [NSRC-1:0] RESET_MASK = '1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            eoi,
  input  logic            inta,
  output logic            intr,
  output logic [ID_W-1:0] vector,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service,
  output logic [NSRC-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t          state;
  logic [NSRC-1:0] irq_s1;
  logic [NSRC-1:0] irq_s2;
  logic [NSRC-1:0] cand;
  logic            cand_any;
  logic [ID_W-1:0] cand_idx;
  logic [NSRC-1:0] grant_onehot;
  logic            inta_take;

  // Two-flop synchroniser for the asynchronous device request lines
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
    end
  end

  // Software mask register (1 = source masked)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mask <= RESET_MASK;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  assign cand         = pending & ~mask;
  assign cand_any     = |cand;
  assign inta_take    = (state == REQ) && inta;
  assign grant_onehot = {{(NSRC-1){1'b0}}, 1'b1} << vector;

  // Fixed-priority pick: lowest set candidate index wins
  always_comb begin
    logic found;
    cand_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (cand[i] && !found) begin
        cand_idx = ID_W'(i);
        found    = 1'b1;
      end
    end
  end

`ifdef SC_INTR_EDGE_EN
  logic [NSRC-1:0] irq_s2_d;
  logic [NSRC-1:0] pend_rise;
  logic [NSRC-1:0] pend_clr;

  assign pend_rise = irq_s2 & ~irq_s2_d;
  assign pend_clr  = inta_take ? grant_onehot : '0;

  // Edge-mode pending: set on a synchronised rising edge, cleared on
  // acknowledge of the granted source; a set in the same cycle wins
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq_s2_d <= '0;
      pending  <= '0;
    end else begin
      irq_s2_d <= irq_s2;
      pending  <= (pending & ~pend_clr) | pend_rise;
    end
  end
`else
  // Level-mode pending: follows the synchronised request lines
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
    end else begin
      pending <= irq_s2;
    end
  end
`endif

  // Grant FSM: arbitrate in IDLE, hold the frozen vector in REQ until inta,
  // keep the source in service until eoi
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      intr       <= 1'b0;
      vector     <= '0;
      in_service <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_any) begin
            vector <= cand_idx;
            intr   <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (inta_take) begin
            in_service <= grant_onehot;
            intr       <= 1'b0;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            in_service <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          intr       <= 1'b0;
          in_service <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_intr_ctrl.sv
// Self-checking bench for sc_intr_ctrl (NSRC=8, ID_W=3) with a behavioural
// reference model; directed scenarios followed by randomized traffic.
module tb_sc_intr_ctrl;

  logic       clock;
  logic       resetn;
  logic [7:0] irq;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       eoi;
  logic       inta;
  logic       intr;
  logic [2:0] vector;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] mask;

  int n_total = 0;
  int n_bad   = 0;

  sc_intr_ctrl #(
    .NSRC      (8),
    .ID_W      (3),
    .RESET_MASK(8'hFF)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .irq       (irq),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .eoi       (eoi),
    .inta      (inta),
    .intr      (intr),
    .vector    (vector),
    .pending   (pending),
    .in_service(in_service),
    .mask      (mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: phase 0 = waiting for a candidate, 1 = granted and
  // awaiting acknowledge, 2 = in service awaiting eoi.
  int         m_phase;
  logic       m_intr;
  int         m_vec;
  logic [7:0] m_pend;
  logic [7:0] m_isv;
  logic [7:0] m_mask;
  logic [7:0] hist [4];  // irq samples at the last four edges, [0] newest

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_intr  = 1'b0;
    m_vec   = 0;
    m_pend  = '0;
    m_isv   = '0;
    m_mask  = 8'hFF;
    for (int i = 0; i < 4; i++) hist[i] = '0;
  endtask

  task automatic model_step();
    logic [7:0] cand;
    logic [7:0] clr;
    if (!resetn) begin
      model_reset();
      return;
    end
    cand = m_pend & ~m_mask;
    clr  = '0;
    if (m_phase == 0) begin
      if (cand != 0) begin
        m_vec   = first_set(cand);
        m_intr  = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (inta) begin
        m_isv   = 8'd1 << m_vec;
        clr     = 8'd1 << m_vec;
        m_intr  = 1'b0;
        m_phase = 2;
      end
    end else begin
      if (eoi) begin
        m_isv   = '0;
        m_phase = 0;
      end
    end
    if (mask_we) m_mask = mask_wdata;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = irq;
    // a request sampled two edges ago is what reaches pending now
`ifdef SC_INTR_EDGE_EN
    m_pend = (m_pend & ~clr) | (hist[2] & ~hist[3]);
`else
    m_pend = hist[2] | (clr & 8'h00);
`endif
  endtask

  task automatic compare_all();
    check("intr",       32'(intr),       32'(m_intr));
    check("vector",     32'(vector),     32'(m_vec));
    check("pending",    32'(pending),    32'(m_pend));
    check("in_service", 32'(in_service), 32'(m_isv));
    check("mask",       32'(mask),       32'(m_mask));
  endtask

  // One clock: inputs were set at the falling edge, model and DUT both
  // advance on the rising edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1 compare_all();
    @(negedge clock);
    mask_we = 1'b0;
    inta    = 1'b0;
    eoi     = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    tick();
  endtask

  task automatic wait_intr(input string tag, input int max_cycles);
    int k;
    k = 0;
    while (!intr && k < max_cycles) begin
      tick();
      k++;
    end
    check(tag, 32'(intr), 32'd1);
  endtask

  task automatic async_reset_check();
    #2 resetn = 1'b0;
    #1;
    check("rst_intr",       32'(intr),       32'd0);
    check("rst_mask",       32'(mask),       32'hFF);
    check("rst_pending",    32'(pending),    32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    check("rst_vector",     32'(vector),     32'd0);
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn     = 1'b0;
    irq        = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    eoi        = 1'b0;
    inta       = 1'b0;
    model_reset();
    @(negedge clock);
    ticks(2);
    resetn = 1'b1;
    ticks(2);

    // Single source, then reset while the request is outstanding
    write_mask(8'h00);
    irq = 8'h20;
    wait_intr("single_intr", 6);
    check("single_vec", 32'(vector), 32'd5);
    ticks(2);
    check("req_hold_intr", 32'(intr), 32'd1);
    async_reset_check();
    irq = 8'h00;
    ticks(4);
    write_mask(8'h00);
    irq = 8'h20;
    wait_intr("single_intr2", 6);
    inta = 1'b1;
    tick();
    check("single_isv", 32'(in_service), 32'h20);
    check("single_ack_intr", 32'(intr), 32'd0);
    irq = 8'h00;
    ticks(2);
    eoi = 1'b1;
    tick();
    check("single_eoi_isv", 32'(in_service), 32'd0);
    ticks(5);

    // Priority: 2 beats 6, then 6 one cycle after eoi
    irq = 8'h44;
    wait_intr("prio_intr", 6);
    check("prio_vec2", 32'(vector), 32'd2);
    inta = 1'b1;
    tick();
    irq = 8'h40;
    ticks(4);
    eoi = 1'b1;
    tick();
    tick();
    check("prio_intr6", 32'(intr), 32'd1);
    check("prio_vec6", 32'(vector), 32'd6);
    inta = 1'b1;
    tick();
    irq = 8'h00;
    ticks(4);
    eoi = 1'b1;
    tick();
    ticks(4);

    // Masked source stays quiet until unmasked
    write_mask(8'h08);
    irq = 8'h08;
    ticks(6);
    check("mask_quiet", 32'(intr), 32'd0);
    write_mask(8'h00);
    tick();
    check("unmask_intr", 32'(intr), 32'd1);
    check("unmask_vec", 32'(vector), 32'd3);
    inta = 1'b1;
    tick();
    irq = 8'h00;
    ticks(4);
    eoi = 1'b1;
    tick();
    ticks(4);

    // No preemption: 4 granted, 0 arrives before inta
    irq = 8'h10;
    wait_intr("nopre_intr", 6);
    irq = 8'h11;
    ticks(5);
    check("nopre_vec", 32'(vector), 32'd4);
    inta = 1'b1;
    tick();
    irq = 8'h01;
    ticks(3);
    eoi = 1'b1;
    tick();
    tick();
    check("after_eoi_vec0", 32'(vector), 32'd0);
    check("after_eoi_intr", 32'(intr), 32'd1);
    inta = 1'b1;
    tick();
    irq = 8'h00;
    ticks(4);
    eoi = 1'b1;
    tick();
    ticks(4);

    // Held level through inta and eoi
    irq = 8'h02;
    wait_intr("held_intr", 6);
    inta = 1'b1;
    tick();
    ticks(3);
    eoi = 1'b1;
    tick();
    tick();
`ifdef SC_INTR_EDGE_EN
    check("held_regrant", 32'(intr), 32'd0);
`else
    check("held_regrant", 32'(intr), 32'd1);
    check("held_vec", 32'(vector), 32'd1);
`endif
    irq = 8'h00;
    ticks(6);

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) irq[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 31) == 0) begin
        mask_we    = 1'b1;
        mask_wdata = 8'($urandom) & 8'($urandom);
      end
      if (m_intr) inta = ($urandom_range(0, 2) == 0);
      else        inta = ($urandom_range(0, 15) == 0);
      if (m_phase == 2) eoi = ($urandom_range(0, 3) == 0);
      else              eoi = ($urandom_range(0, 15) == 0);
      if (c == 2000) async_reset_check();
      else           tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
